// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage MIPS core.
// Decides PC / IF/ID advance, hold or flush each cycle, injects ID/EX bubbles,
// sequences multi-cycle load-use stalls and multiplies, and counts stall cycles.
module hazard_controller #(
  parameter int LOAD_BUBBLES = 1,  // 1..3
  parameter int MUL_CYCLES   = 4   // 2..15
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [1:0]  IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic        IDEX_Mul,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        IFID_UsesRt,
  input  logic        IFID_Jump,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        controlMuxSignal,
  output logic        IDEXWrite,
  output logic        EXMEMBubble,
  output logic [15:0] StallCycles
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MUL_WAIT} state_t;

  // Counter preloads: the first stall cycle is spent in RUN, so the
  // wait states only cover the remainder.
  localparam logic [3:0] MUL_INIT  = 4'(MUL_CYCLES - 2);
  localparam logic [3:0] LOAD_INIT = (LOAD_BUBBLES > 1) ? 4'(LOAD_BUBBLES - 2) : 4'd0;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       loaduse;

  assign loaduse = (IDEX_MemRead != 2'b00) && (IDEX_Rt != 5'd0) &&
                   ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  // Next-state and hazard enables; reset overrides everything combinationally.
  always_comb begin
    PCWrite          = 1'b1;
    IFIDWrite        = 1'b1;
    IFIDFlush        = 1'b0;
    controlMuxSignal = 1'b1;
    IDEXWrite        = 1'b1;
    EXMEMBubble      = 1'b0;
    state_nx         = state;
    cnt_nx           = cnt;
    case (state)
      RUN: begin
        if (BranchTaken) begin
          // Branch kills both younger slots in one cycle.
          IFIDFlush        = 1'b1;
          controlMuxSignal = 1'b0;
        end else if (IDEX_Mul) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
          state_nx    = MUL_WAIT;
          cnt_nx      = MUL_INIT;
        end else if (loaduse) begin
          PCWrite          = 1'b0;
          IFIDWrite        = 1'b0;
          controlMuxSignal = 1'b0;
          if (LOAD_BUBBLES > 1) begin
            state_nx = LOAD_STALL;
            cnt_nx   = LOAD_INIT;
          end
        end else if (IFID_Jump) begin
          IFIDFlush = 1'b1;
        end
      end
      LOAD_STALL: begin
        // A jump held in ID waits: no flush while IF/ID is frozen.
        PCWrite          = 1'b0;
        IFIDWrite        = 1'b0;
        controlMuxSignal = 1'b0;
        if (cnt == 4'd0) state_nx = RUN;
        else             cnt_nx   = cnt - 4'd1;
      end
      MUL_WAIT: begin
        if (cnt != 4'd0) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
          cnt_nx      = cnt - 4'd1;
        end else begin
          // Release cycle: the multiply leaves EX with default enables.
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
    if (!Rst_n) begin
      PCWrite          = 1'b0;
      IFIDWrite        = 1'b0;
      IFIDFlush        = 1'b1;
      controlMuxSignal = 1'b0;
      IDEXWrite        = 1'b1;
      EXMEMBubble      = 1'b1;
    end
  end

  // State, sequencing counter and saturating stall-cycle counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= RUN;
      cnt         <= 4'd0;
      StallCycles <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!PCWrite && (StallCycles != 16'hFFFF))
        StallCycles <= StallCycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a vector table of single-cycle decisions,
// hand sequences for the multi-cycle corners, and random stimulus against a
// remaining-cycles reference model. Two instances: LOAD_BUBBLES=1 and 2.
module tb_hazard_controller;

  logic       Clk, Rst_n;
  logic [1:0] IDEX_MemRead;
  logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
  logic       IDEX_Mul, IFID_UsesRt, IFID_Jump, BranchTaken;

  logic        pcw[2], ifidw[2], flush[2], cms[2], idexw[2], exmb[2];
  logic [15:0] stall[2];

  hazard_controller #(.LOAD_BUBBLES(1), .MUL_CYCLES(4)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IDEX_Mul(IDEX_Mul), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRt(IFID_UsesRt), .IFID_Jump(IFID_Jump), .BranchTaken(BranchTaken),
    .PCWrite(pcw[0]), .IFIDWrite(ifidw[0]), .IFIDFlush(flush[0]),
    .controlMuxSignal(cms[0]), .IDEXWrite(idexw[0]), .EXMEMBubble(exmb[0]),
    .StallCycles(stall[0]));

  hazard_controller #(.LOAD_BUBBLES(2), .MUL_CYCLES(4)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IDEX_Mul(IDEX_Mul), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRt(IFID_UsesRt), .IFID_Jump(IFID_Jump), .BranchTaken(BranchTaken),
    .PCWrite(pcw[1]), .IFIDWrite(ifidw[1]), .IFIDFlush(flush[1]),
    .controlMuxSignal(cms[1]), .IDEXWrite(idexw[1]), .EXMEMBubble(exmb[1]),
    .StallCycles(stall[1]));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Output bundles {PCWrite, IFIDWrite, IFIDFlush, controlMuxSignal, IDEXWrite, EXMEMBubble}
  localparam logic [5:0] O_RST = 6'b001011;
  localparam logic [5:0] O_DEF = 6'b110110;
  localparam logic [5:0] O_LDS = 6'b000010;
  localparam logic [5:0] O_MUL = 6'b000101;
  localparam logic [5:0] O_BR  = 6'b111010;
  localparam logic [5:0] O_JMP = 6'b111110;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [5:0] outs(int k);
    return {pcw[k], ifidw[k], flush[k], cms[k], idexw[k], exmb[k]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    IDEX_MemRead = 2'b00; IDEX_Rt = 5'd0; IDEX_Mul = 1'b0;
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
    IFID_Jump = 1'b0; BranchTaken = 1'b0;
  endtask

  // Call right after a falling edge: async reset pulse with no rising edge.
  task automatic rst_pulse();
    Rst_n = 1'b0;
    #1 Rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Tracks how many cycles of an ongoing stall remain, not FSM states.
  int ld_left[2], mul_left[2], stall_m[2];
  int lb_of[2] = '{1, 2};
  localparam int MC = 4;

  function automatic bit lu_now();
    return (IDEX_MemRead != 0) && (IDEX_Rt != 0) &&
           ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
  endfunction

  function automatic logic [5:0] model_out(int k);
    if (!Rst_n)          return O_RST;
    if (mul_left[k] > 0) return (mul_left[k] > 1) ? O_MUL : O_DEF;
    if (ld_left[k] > 0)  return O_LDS;
    if (BranchTaken)     return O_BR;
    if (IDEX_Mul)        return O_MUL;
    if (lu_now())        return O_LDS;
    if (IFID_Jump)       return O_JMP;
    return O_DEF;
  endfunction

  task automatic model_step(int k);
    logic [5:0] o;
    o = model_out(k);
    if (!Rst_n) begin
      ld_left[k] = 0; mul_left[k] = 0; stall_m[k] = 0;
      return;
    end
    if (!o[5] && stall_m[k] < 65535) stall_m[k]++;
    if (mul_left[k] > 0)                 mul_left[k]--;
    else if (ld_left[k] > 0)             ld_left[k]--;
    else if (!BranchTaken && IDEX_Mul)   mul_left[k] = MC - 1;
    else if (!BranchTaken && lu_now())   ld_left[k] = lb_of[k] - 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst;
    logic [1:0] memrd;
    logic [4:0] xrt;
    logic       mul;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       jmp;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] m, logic [4:0] x, logic u,
                              logic [4:0] s, logic [4:0] t, logic ur, logic j,
                              logic b, logic [5:0] e);
    vec_t v;
    v.rst = r; v.memrd = m; v.xrt = x; v.mul = u; v.rs = s; v.rt = t;
    v.uses = ur; v.jmp = j; v.br = b; v.exp = e;
    return v;
  endfunction

  vec_t vt[12];

  initial begin
    vt[0]  = mk(0, 2'b01, 5'd8, 0, 5'd8, 5'd0, 0, 1, 0, O_RST);
    vt[1]  = mk(1, 2'b00, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, O_DEF);
    vt[2]  = mk(1, 2'b01, 5'd8, 0, 5'd8, 5'd3, 0, 0, 0, O_LDS);
    vt[3]  = mk(1, 2'b10, 5'd9, 0, 5'd1, 5'd9, 1, 0, 0, O_LDS);
    vt[4]  = mk(1, 2'b10, 5'd9, 0, 5'd1, 5'd9, 0, 0, 0, O_DEF);
    vt[5]  = mk(1, 2'b00, 5'd8, 0, 5'd8, 5'd8, 1, 0, 0, O_DEF);
    vt[6]  = mk(1, 2'b11, 5'd0, 0, 5'd0, 5'd0, 1, 0, 0, O_DEF);
    vt[7]  = mk(1, 2'b00, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, O_MUL);
    vt[8]  = mk(1, 2'b01, 5'd4, 1, 5'd4, 5'd0, 0, 1, 0, O_MUL);
    vt[9]  = mk(1, 2'b01, 5'd4, 1, 5'd4, 5'd0, 0, 1, 1, O_BR);
    vt[10] = mk(1, 2'b00, 5'd0, 0, 5'd0, 5'd0, 0, 1, 0, O_JMP);
    vt[11] = mk(1, 2'b01, 5'd7, 0, 5'd7, 5'd0, 0, 1, 0, O_LDS);

    Rst_n = 1'b0;
    idle();
    #2;
    chk("reset_outs", outs(0), O_RST);
    chk("reset_cnt", stall[0], 0);

    // Table: each vector evaluated from a freshly reset RUN state.
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      Rst_n = 1'b0;
      IDEX_MemRead = vt[i].memrd; IDEX_Rt = vt[i].xrt; IDEX_Mul = vt[i].mul;
      IFID_Rs = vt[i].rs; IFID_Rt = vt[i].rt; IFID_UsesRt = vt[i].uses;
      IFID_Jump = vt[i].jmp; BranchTaken = vt[i].br;
      #1 Rst_n = vt[i].rst;
      #1;
      chk($sformatf("vec%0d_lb1", i), outs(0), vt[i].exp);
      chk($sformatf("vec%0d_lb2", i), outs(1), vt[i].exp);
    end

    // Load-use, LOAD_BUBBLES=1: one stall cycle, then flow.
    @(negedge Clk); idle(); rst_pulse();
    IDEX_MemRead = 2'b01; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    #1 chk("lu1_stall", outs(0), O_LDS);
    @(negedge Clk); idle();
    #1 chk("lu1_release", outs(0), O_DEF);
    chk("lu1_count", stall[0], 1);
    @(negedge Clk); rst_pulse();
    IDEX_MemRead = 2'b01; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    #1 chk("lu1_r0_nostall", outs(0), O_DEF);

    // Load-use on rt, LOAD_BUBBLES=2: two stall cycles.
    @(negedge Clk); idle(); rst_pulse();
    IDEX_MemRead = 2'b10; IDEX_Rt = 5'd5; IFID_Rt = 5'd5; IFID_UsesRt = 1'b1; IFID_Rs = 5'd3;
    #1 chk("lu2_c0", outs(1), O_LDS);
    @(negedge Clk);
    #1 chk("lu2_c1", outs(1), O_LDS);
    @(negedge Clk); idle();
    #1 chk("lu2_release", outs(1), O_DEF);
    chk("lu2_count", stall[1], 2);
    @(negedge Clk); rst_pulse();
    IDEX_MemRead = 2'b10; IDEX_Rt = 5'd5; IFID_Rt = 5'd5; IFID_UsesRt = 1'b0; IFID_Rs = 5'd3;
    #1 chk("lu2_norT", outs(1), O_DEF);

    // Multiply: 3 stall cycles then a release cycle.
    @(negedge Clk); idle(); rst_pulse();
    IDEX_Mul = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("mul_stall%0d", c), outs(0), O_MUL);
      @(negedge Clk);
    end
    #1 chk("mul_release", outs(0), O_DEF);
    @(negedge Clk); idle();
    #1 chk("mul_count", stall[0], 3);
    chk("mul_after", outs(0), O_DEF);

    // Branch beats jump and load-use; no stall counted.
    @(negedge Clk); rst_pulse();
    BranchTaken = 1'b1; IFID_Jump = 1'b1;
    IDEX_MemRead = 2'b01; IDEX_Rt = 5'd6; IFID_Rs = 5'd6;
    #1 chk("br_prio", outs(0), O_BR);
    @(negedge Clk); idle();
    #1 chk("br_count", stall[0], 0);

    // Jump held through a load-use stall flushes on release only.
    @(negedge Clk); rst_pulse();
    IFID_Jump = 1'b1; IDEX_MemRead = 2'b01; IDEX_Rt = 5'd6; IFID_Rs = 5'd6;
    #1 chk("jmp_stalled", outs(0), O_LDS);
    chk("jmp_stalled_lb2", outs(1), O_LDS);
    @(negedge Clk); IDEX_MemRead = 2'b00;
    #1 chk("jmp_release", outs(0), O_JMP);
    chk("jmp_held_lb2", outs(1), O_LDS);
    @(negedge Clk);
    #1 chk("jmp_release_lb2", outs(1), O_JMP);

    // Reset in the 2nd cycle of MUL_WAIT aborts the multiply.
    @(negedge Clk); idle(); rst_pulse();
    IDEX_Mul = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    #1 chk("mulrst_pre", outs(0), O_MUL);
    Rst_n = 1'b0;
    #1 chk("mulrst_outs", outs(0), O_RST);
    chk("mulrst_cnt", stall[0], 0);
    Rst_n = 1'b1; IDEX_Mul = 1'b0;
    #1 chk("mulrst_run", outs(0), O_DEF);
    @(negedge Clk);
    #1 chk("mulrst_cnt_after", stall[0], 0);

    // Saturation: load-use held every cycle.
    @(negedge Clk); rst_pulse();
    IDEX_MemRead = 2'b01; IDEX_Rt = 5'd2; IFID_Rs = 5'd2;
    repeat (65534) @(negedge Clk);
    #1 chk("sat_fffe", stall[0], 16'hFFFE);
    repeat (6) @(negedge Clk);
    #1 chk("sat_ffff", stall[0], 16'hFFFF);

    // Random stimulus against the model, both instances.
    @(negedge Clk); idle(); Rst_n = 1'b0;
    for (int k = 0; k < 2; k++) model_step(k);
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      Rst_n        = ($urandom_range(0, 59) != 0);
      IDEX_MemRead = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      IDEX_Rt      = 5'($urandom_range(0, 3));
      IFID_Rs      = 5'($urandom_range(0, 3));
      IFID_Rt      = 5'($urandom_range(0, 3));
      IFID_UsesRt  = 1'($urandom_range(0, 1));
      IDEX_Mul     = ($urandom_range(0, 7) == 0);
      IFID_Jump    = ($urandom_range(0, 3) == 0);
      BranchTaken  = ($urandom_range(0, 7) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d_outs_dut%0d", n, k + 1), outs(k), model_out(k));
        chk($sformatf("rnd%0d_cnt_dut%0d", n, k + 1), stall[k], Rst_n ? stall_m[k] : 0);
        model_step(k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard sequencer for the 5-stage MIPS core. Each cycle it decides whether the PC and IF/ID advance, hold or flush. It drives `controlMuxSignal`, the select of the ID-stage control-zeroing mux, to inject bubbles into ID/EX. It also sequences multi-cycle load-use stalls and multi-cycle multiplies in EX, and keeps a saturating stall-cycle counter.

## Interface

Parameters:
- LOAD_BUBBLES, 1: bubbles per load-use hazard (1 with MEM/WB forwarding, 2 without); legal 1..3
- MUL_CYCLES, 4: cycles a multiply occupies EX; legal 2..15

Ports:
- Clk  in  1  clock; all state on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- IDEX_MemRead  in  2  MemRead field of the instruction in EX; nonzero = load
- IDEX_Rt  in  5  destination of the load in EX
- IDEX_Mul  in  1  instruction in EX is a multiply
- IFID_Rs  in  5  rs of the instruction in ID
- IFID_Rt  in  5  rt of the instruction in ID
- IFID_UsesRt  in  1  ID instruction reads rt
- IFID_Jump  in  1  j/jal/jr resolved in ID
- BranchTaken  in  1  branch in EX resolved taken
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID write enable
- IFIDFlush  out  1  zero IF/ID on next edge
- controlMuxSignal  out  1  1 = pass ID control, 0 = bubble into ID/EX
- IDEXWrite  out  1  ID/EX write enable
- EXMEMBubble  out  1  load a bubble into EX/MEM
- StallCycles  out  16  count of cycles with PCWrite=0

## Operation

- FSM states are RUN, LOAD_STALL and MUL_WAIT, with a 4-bit down-counter `cnt`.
- Default outputs (no hazard): PCWrite=1, IFIDWrite=1, IFIDFlush=0, controlMuxSignal=1, IDEXWrite=1, EXMEMBubble=0.
- `loaduse` = IDEX_MemRead≠0 & IDEX_Rt≠0 & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
- Priority in RUN, highest first:
  1. BranchTaken: IFIDFlush=1, controlMuxSignal=0, PCWrite=1. Stay in RUN. This overrides loaduse and IFID_Jump.
  2. IDEX_Mul: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1. Set cnt=MUL_CYCLES-2 and go to MUL_WAIT.
  3. loaduse: PCWrite=0, IFIDWrite=0, controlMuxSignal=0. If LOAD_BUBBLES>1, set cnt=LOAD_BUBBLES-2 and go to LOAD_STALL; otherwise stay in RUN.
  4. IFID_Jump: IFIDFlush=1, everything else default.
- LOAD_STALL: PCWrite=0, IFIDWrite=0, controlMuxSignal=0, IFIDFlush=0. If cnt==0, go to RUN; otherwise decrement cnt.
- MUL_WAIT:
  - cnt≠0: same outputs as the RUN multiply stall; decrement cnt.
  - cnt==0: default outputs (release, the multiply advances); go to RUN.
- Stalls override jumps. A jump held in ID gets its IFIDFlush only in the first cycle where IFIDWrite=1.
- BranchTaken is ignored in LOAD_STALL and MUL_WAIT. EX then holds a bubble or a multiply, so a taken branch cannot occur.
- StallCycles increments on each edge where Rst_n=1 and PCWrite=0, and saturates at 16'hFFFF.
- Outputs are combinational from state, cnt and inputs, except StallCycles, which is registered.

## Timing

- Hazard decisions are combinational, with zero-cycle latency from inputs to enables.
- Load-use stall: exactly LOAD_BUBBLES consecutive cycles with PCWrite=0, then normal flow.
- Multiply: EX is held MUL_CYCLES cycles in total, i.e. MUL_CYCLES-1 stall cycles plus 1 release cycle. EXMEMBubble=1 on every stall cycle.
- Branch flush costs 2 slots in a single cycle: IF/ID is zeroed and an ID/EX bubble is inserted.
- Jump flush costs 1 slot.
- Reset (Rst_n=0, asynchronous):
  - state=RUN, cnt=0, StallCycles=0.
  - Outputs are forced to PCWrite=0, IFIDWrite=0, IFIDFlush=1, controlMuxSignal=0, IDEXWrite=1, EXMEMBubble=1, regardless of the other inputs.
  - Reset mid-stall aborts the stall. The first cycle after deassertion evaluates fresh from RUN.

## Test plan

- Load-use with LOAD_BUBBLES=1: IDEX_MemRead=2'b01, IDEX_Rt=8, IFID_Rs=8 for one cycle -> PCWrite=0, IFIDWrite=0, controlMuxSignal=0 for exactly 1 cycle. StallCycles=1. The same stimulus with IDEX_Rt=0 gives no stall.
- LOAD_BUBBLES=2, match on rt with IFID_UsesRt=1 -> 2 stall cycles (RUN→LOAD_STALL→RUN). Repeat with IFID_UsesRt=0 -> no stall.
- Multiply with MUL_CYCLES=4: IDEX_Mul=1 -> 3 cycles with IDEXWrite=0 and EXMEMBubble=1, then a 4th cycle with all defaults. StallCycles=3.
- BranchTaken=1 together with IFID_Jump=1 and loaduse true -> IFIDFlush=1, controlMuxSignal=0, PCWrite=1, IFIDWrite=1, with no stall counted.
- IFID_Jump=1 during a loaduse stall -> IFIDFlush=0 while stalled, then IFIDFlush=1 in the first release cycle.
- Rst_n pulsed low in the 2nd cycle of MUL_WAIT -> outputs take reset values immediately (no clock edge). After deassertion: state RUN, StallCycles=0. Force 65,540 stall cycles -> StallCycles holds 16'hFFFF.
